// File: rtl/dct_mac_accum_if.sv
// Handshake bundle between the multiplier register and the DCT accumulate stage.
// The master side drives the product stream; the slave side returns the rounded coefficient.
interface dct_mac_accum_if #(
  parameter int unsigned MULT_W = 24,
  parameter int unsigned OUT_W  = 12
) ();
  logic                     ena;
  logic signed [MULT_W-1:0] mult_res;
  logic                     mult_vld;
  logic                     dstrb;
  logic signed [OUT_W-1:0]  dout;
  logic                     douten;
  logic                     sat;
  logic                     abort;

  modport master (
    output ena, mult_res, mult_vld, dstrb,
    input  dout, douten, sat, abort
  );

  modport slave (
    input  ena, mult_res, mult_vld, dstrb,
    output dout, douten, sat, abort
  );
endinterface

// File: rtl/dct_mac_accum.sv
// DCT accumulate stage: sums N_TERMS signed products, then rounds, saturates and
// strobes out one coefficient per sum. An early dstrb discards the partial sum.
module dct_mac_accum #(
  parameter int unsigned MULT_W    = 24,
  parameter int unsigned ACC_W     = 27,
  parameter int unsigned N_TERMS   = 8,
  parameter int unsigned FRAC_BITS = 11,
  parameter int unsigned OUT_W     = 12
) (
  input logic            clk,
  input logic            rst,
  dct_mac_accum_if.slave acc_bus
);

  localparam int unsigned CntW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int unsigned ExtW = ACC_W + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N_TERMS - 1);
  localparam logic signed [ExtW-1:0] RndHalf =
    {{(ExtW - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
  localparam logic signed [ExtW-1:0] MaxOut = {{(ExtW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ExtW-1:0] MinOut = {{(ExtW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  if (ACC_W < MULT_W + $clog2(N_TERMS)) begin : g_acc_w_check
    $error("dct_mac_accum: ACC_W too narrow, accumulator could wrap");
  end

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e                  r_state, w_state_nxt;
  logic [CntW-1:0]         r_cnt, w_cnt_nxt;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic signed [OUT_W-1:0] r_dout, w_dout_nxt;
  logic                    r_douten, w_douten_nxt;
  logic                    r_sat, w_sat_nxt;
  logic                    r_abort, w_abort_nxt;

  logic signed [ACC_W-1:0] w_term, w_sum;
  logic signed [ExtW-1:0]  w_rnd, w_shift;
  logic signed [OUT_W-1:0] w_rs;
  logic                    w_clip;

  assign w_term  = {{(ACC_W - MULT_W){acc_bus.mult_res[MULT_W-1]}}, acc_bus.mult_res};
  assign w_sum   = r_acc + w_term;
  // One guard bit so adding the half-LSB can never wrap.
  assign w_rnd   = {w_sum[ACC_W-1], w_sum} + RndHalf;
  assign w_shift = w_rnd >>> FRAC_BITS;

  always_comb begin
    w_rs   = w_shift[OUT_W-1:0];
    w_clip = 1'b0;
    if (w_shift > MaxOut) begin
      w_rs   = MaxOut[OUT_W-1:0];
      w_clip = 1'b1;
    end else if (w_shift < MinOut) begin
      w_rs   = MinOut[OUT_W-1:0];
      w_clip = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_dout_nxt   = r_dout;
    w_douten_nxt = 1'b0;
    w_sat_nxt    = 1'b0;
    w_abort_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (acc_bus.mult_vld && acc_bus.dstrb) begin
          w_acc_nxt   = w_term;
          w_cnt_nxt   = CntW'(1);
          w_state_nxt = StAccum;
        end
      end
      StAccum: begin
        if (acc_bus.mult_vld) begin
          if (acc_bus.dstrb) begin
            w_abort_nxt = 1'b1;
            w_acc_nxt   = w_term;
            w_cnt_nxt   = CntW'(1);
          end else if (r_cnt == LastCnt) begin
            w_dout_nxt   = w_rs;
            w_douten_nxt = 1'b1;
            w_sat_nxt    = w_clip;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_state_nxt  = StIdle;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + CntW'(1);
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // ena gates every register, so pulse outputs stretch across a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_dout   <= '0;
      r_douten <= 1'b0;
      r_sat    <= 1'b0;
      r_abort  <= 1'b0;
    end else if (acc_bus.ena) begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_dout   <= w_dout_nxt;
      r_douten <= w_douten_nxt;
      r_sat    <= w_sat_nxt;
      r_abort  <= w_abort_nxt;
    end
  end

  assign acc_bus.dout   = r_dout;
  assign acc_bus.douten = r_douten;
  assign acc_bus.sat    = r_sat;
  assign acc_bus.abort  = r_abort;

endmodule

// File: tb/tb_dct_mac_accum.sv
// Scoreboard bench for dct_mac_accum: directed sums push expected coefficients,
// a negedge monitor pops them on each strobe and checks held outputs during stalls.
module tb_dct_mac_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct_mac_accum_if #(.MULT_W(24), .OUT_W(12)) bus ();

  dct_mac_accum #(
    .MULT_W   (24),
    .ACC_W    (27),
    .N_TERMS  (8),
    .FRAC_BITS(11),
    .OUT_W    (12)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .acc_bus(bus)
  );

  typedef struct {
    int d;
    bit s;
    int c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int aborts_seen = 0;
  bit edge_en = 1'b0;
  int prev_dout = 0;
  bit prev_douten = 1'b0, prev_sat = 1'b0, prev_abort = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    edge_en = bus.ena;
  end

  // Monitor: pops on a fresh strobe, otherwise checks outputs held through a stall.
  always @(negedge clk) begin
    if (!rst) begin
      if (edge_en) begin
        if (bus.douten) begin
          if (q.size() == 0) begin
            chk("unexpected_douten", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("dout", int'($signed(bus.dout)), e.d);
            chk("sat", int'(bus.sat), int'(e.s));
            if (e.c >= 0) chk("latency_cycle", cyc, e.c);
          end
        end
        if (bus.abort) aborts_seen++;
      end else begin
        chk("hold_douten", int'(bus.douten), int'(prev_douten));
        chk("hold_dout", int'($signed(bus.dout)), prev_dout);
        chk("hold_sat", int'(bus.sat), int'(prev_sat));
        chk("hold_abort", int'(bus.abort), int'(prev_abort));
      end
    end
    prev_douten = bus.douten;
    prev_dout   = int'($signed(bus.dout));
    prev_sat    = bus.sat;
    prev_abort  = bus.abort;
  end

  // Drives one term for one enabled cycle; on the last term pushes the expected result.
  task automatic term(input int v, input bit d, input bit last, input int exp_d,
                      input bit exp_s, input bit lat);
    exp_t e;
    bus.ena      = 1'b1;
    bus.mult_vld = 1'b1;
    bus.dstrb    = d;
    bus.mult_res = 24'(v);
    if (last) begin
      e.d = exp_d;
      e.s = exp_s;
      e.c = lat ? cyc + 1 : -1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.mult_vld = 1'b0;
    bus.dstrb    = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.ena      = 1'b1;
    bus.mult_vld = 1'b0;
    bus.dstrb    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic block(input int v0, input int vr, input int exp_d, input bit exp_s);
    term(v0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) term(vr, 1'b0, i == 7, exp_d, exp_s, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, int'($signed(bus.dout)), 0);
    chk({tag, "_douten"}, int'(bus.douten), 0);
    chk({tag, "_sat"}, int'(bus.sat), 0);
    chk({tag, "_abort"}, int'(bus.abort), 0);
  endtask

  initial begin
    bus.ena      = 1'b1;
    bus.mult_vld = 1'b0;
    bus.dstrb    = 1'b0;
    bus.mult_res = '0;
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    term(777, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(3);

    block(2048, 2048, 8, 1'b0);
    idle(2);

    // Same sum with a one-cycle gap between terms 3 and 4.
    term(2048, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    term(2048, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    term(2048, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
    for (int i = 3; i < 8; i++) term(2048, 1'b0, i == 7, 8, 1'b0, 1'b1);
    idle(2);

    block(1024, 0, 1, 1'b0);
    block(1023, 0, 0, 1'b0);
    block(-1024, 0, 0, 1'b0);
    block(-1025, 0, -1, 1'b0);
    block(4194304, 4194304, 2047, 1'b1);
    block(-4194304, -4194304, -2048, 1'b1);
    idle(2);

    // Partial sum cut short, then back-to-back blocks.
    term(5000, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    term(5000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    term(5000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    block(-2048, -2048, -8, 1'b0);
    block(4096, 4096, 16, 1'b0);
    idle(3);

    // Three-cycle ena stall around the final term and the strobe.
    for (int i = 0; i < 7; i++) term(2048, i == 0, 1'b0, 0, 1'b0, 1'b0);
    bus.ena      = 1'b0;
    bus.mult_vld = 1'b1;
    bus.mult_res = 24'(999999);
    @(posedge clk);
    #1;
    term(2048, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    bus.ena      = 1'b0;
    bus.mult_vld = 1'b1;
    bus.dstrb    = 1'b1;
    bus.mult_res = 24'(12345);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    idle(2);
    block(2048, 2048, 8, 1'b0);
    idle(3);

    // Asynchronous reset mid-sum, while dout holds a nonzero value.
    term(2048, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    term(2048, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    term(2048, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    term(123, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(3);
    block(1024, 0, 1, 1'b0);
    idle(4);

    chk("pending_results", q.size(), 0);
    chk("abort_pulses", aborts_seen, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
